wb_stage_ex: RTL and testbench

WB_STAGE_EX -- requirements
Module: wb_stage_ex

---
 rtl/wb_stage_ex_if.sv | 41 ++++
 rtl/wb_stage_ex.sv | 135 +++++++++++++
 tb/tb_wb_stage_ex.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_ex_if.sv
// ---------------------------------------------------------------------------
// wb_stage_ex_if: memory-stage -> write-back-stage instruction bus.
//   ms_to_ws_valid : upstream presents an instruction
//   ws_allow_in    : write-back stage accepts it this cycle
//   in_*           : instruction payload (pc, GPR write, CSR access,
//                    ertn marker, exception flags, faulting address)
// master = memory stage (driver), slave = write-back stage.
// ---------------------------------------------------------------------------
interface wb_stage_ex_if #(
    parameter int NUM_EX    = 8,
    parameter int CSR_NUM_W = 14
);
    logic                 ms_to_ws_valid;
    logic                 ws_allow_in;
    logic [31:0]          in_pc;
    logic                 in_gr_we;
    logic [4:0]           in_dest;
    logic [31:0]          in_result;
    logic                 in_csr_re;
    logic                 in_csr_we;
    logic [CSR_NUM_W-1:0] in_csr_num;
    logic [31:0]          in_csr_wmask;
    logic [31:0]          in_csr_wvalue;
    logic                 in_ertn;
    logic [NUM_EX-1:0]    in_ex_vec;
    logic [31:0]          in_vaddr;

    modport master (
        output ms_to_ws_valid, in_pc, in_gr_we, in_dest, in_result,
               in_csr_re, in_csr_we, in_csr_num, in_csr_wmask, in_csr_wvalue,
               in_ertn, in_ex_vec, in_vaddr,
        input  ws_allow_in
    );

    modport slave (
        input  ms_to_ws_valid, in_pc, in_gr_we, in_dest, in_result,
               in_csr_re, in_csr_we, in_csr_num, in_csr_wmask, in_csr_wvalue,
               in_ertn, in_ex_vec, in_vaddr,
        output ws_allow_in
    );
endinterface

// File: rtl/wb_stage_ex.sv
// ---------------------------------------------------------------------------
// wb_stage_ex: write-back pipeline stage with exception commit.
//   clk, resetn        : clock, asynchronous active-low reset
//   ms (slave)         : instruction bus from the memory stage
//   csr_busy           : CSR file cannot complete an access this cycle
//   csr_num/we/wmask/wvalue, csr_rvalue : CSR file port
//   wb_ex, ertn_flush, wb_pc, wb_ecode, wb_esubcode, wb_badv_we, wb_badv
//                      : exception / ertn commit port
//   rf_we/waddr/wdata  : GPR write port (also forwarding bus to decode)
//   instret            : retired-instruction counter
//   debug_wb_*         : trace port
// An instruction retires ("fires") when valid and not waiting on a busy CSR
// file. A faulting or ertn instruction flushes: whatever arrives on the same
// edge is dropped.
// ---------------------------------------------------------------------------
module wb_stage_ex #(
    parameter int                    NUM_EX    = 8,
    parameter logic [6*NUM_EX-1:0]   ECODE_TAB = '0,
    parameter logic [9*NUM_EX-1:0]   ESUB_TAB  = '0,
    parameter logic [NUM_EX-1:0]     BADV_MASK = '0,
    parameter int                    CNT_W     = 32,
    parameter int                    CSR_NUM_W = 14
) (
    input  logic                 clk,
    input  logic                 resetn,
    wb_stage_ex_if.slave         ms,
    input  logic                 csr_busy,
    output logic [CSR_NUM_W-1:0] csr_num,
    input  logic [31:0]          csr_rvalue,
    output logic                 csr_we,
    output logic [31:0]          csr_wmask,
    output logic [31:0]          csr_wvalue,
    output logic                 wb_ex,
    output logic                 ertn_flush,
    output logic [31:0]          wb_pc,
    output logic [5:0]           wb_ecode,
    output logic [8:0]           wb_esubcode,
    output logic                 wb_badv_we,
    output logic [31:0]          wb_badv,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic [CNT_W-1:0]     instret,
    output logic [31:0]          debug_wb_pc,
    output logic [3:0]           debug_wb_rf_we,
    output logic [4:0]           debug_wb_rf_wnum,
    output logic [31:0]          debug_wb_rf_wdata
);
    localparam int KW = (NUM_EX > 1) ? $clog2(NUM_EX) : 1;

    typedef struct packed {
        logic [31:0]          pc;
        logic                 gr_we;
        logic [4:0]           dest;
        logic [31:0]          result;
        logic                 csr_re;
        logic                 csr_we;
        logic [CSR_NUM_W-1:0] csr_num;
        logic [31:0]          csr_wmask;
        logic [31:0]          csr_wvalue;
        logic                 ertn;
        logic [NUM_EX-1:0]    ex_vec;
        logic [31:0]          vaddr;
    } stage_t;

    stage_t          st;
    stage_t          st_in;
    logic            ws_valid;
    logic            ws_ready_go;
    logic            fire;
    logic            ex_any;
    logic            flush;
    logic [KW-1:0]   ex_k;

    assign st_in = '{pc: ms.in_pc, gr_we: ms.in_gr_we, dest: ms.in_dest,
                     result: ms.in_result, csr_re: ms.in_csr_re,
                     csr_we: ms.in_csr_we, csr_num: ms.in_csr_num,
                     csr_wmask: ms.in_csr_wmask, csr_wvalue: ms.in_csr_wvalue,
                     ertn: ms.in_ertn, ex_vec: ms.in_ex_vec, vaddr: ms.in_vaddr};

    // Only a CSR access can stall, and only while the CSR file is busy.
    assign ws_ready_go    = !(ws_valid && (st.csr_re || st.csr_we) && csr_busy);
    assign ms.ws_allow_in = !ws_valid || ws_ready_go;
    assign fire           = ws_valid && ws_ready_go;
    assign ex_any         = |st.ex_vec;
    assign flush          = fire && (ex_any || st.ertn);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
            st       <= '0;
            instret  <= '0;
        end else begin
            if (flush)
                ws_valid <= 1'b0;
            else if (ms.ws_allow_in)
                ws_valid <= ms.ms_to_ws_valid;
            // Payload holds while stalled; a load on a flush edge is harmless
            // because ws_valid is cleared on that same edge.
            if (ms.ms_to_ws_valid && ms.ws_allow_in)
                st <= st_in;
            if (fire && !ex_any)
                instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Lowest set exception bit has priority: scan downward, last hit wins.
    always_comb begin
        ex_k = '0;
        for (int i = NUM_EX - 1; i >= 0; i--)
            if (st.ex_vec[i]) ex_k = KW'(i);
    end

    assign wb_ex       = fire && ex_any;
    assign ertn_flush  = fire && st.ertn && !ex_any;
    assign wb_ecode    = wb_ex ? ECODE_TAB[6*ex_k +: 6] : 6'd0;
    assign wb_esubcode = wb_ex ? ESUB_TAB[9*ex_k +: 9] : 9'd0;
    assign wb_badv_we  = wb_ex && BADV_MASK[ex_k];
    assign wb_badv     = st.vaddr;
    assign wb_pc       = st.pc;

    assign rf_we    = fire && st.gr_we && !ex_any;
    assign rf_waddr = st.dest;
    assign rf_wdata = st.csr_re ? csr_rvalue : st.result;

    assign csr_we     = fire && st.csr_we && !ex_any;
    assign csr_num    = st.csr_num;
    assign csr_wmask  = st.csr_wmask;
    assign csr_wvalue = st.csr_wvalue;

    assign debug_wb_pc       = st.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
endmodule

// File: tb/tb_wb_stage_ex.sv
// ---------------------------------------------------------------------------
// tb_wb_stage_ex: scoreboard bench for wb_stage_ex. The driver decides, per
// accepted instruction, what commit it must produce (or that it is dropped
// behind a flush) and queues it; the monitor pops and compares whenever the
// DUT shows a commit (rf_we / csr_we / wb_ex / ertn_flush).
// ---------------------------------------------------------------------------
module tb_wb_stage_ex;
    localparam int NUM_EX = 8;
    localparam int CNT_W  = 4;
    localparam int CW     = 14;
    localparam logic [47:0] ECODE_TAB = {6'h11, 6'h10, 6'h0F, 6'h0E,
                                         6'h0D, 6'h0C, 6'h0B, 6'h0A};
    localparam logic [71:0] ESUB_TAB  = {9'h107, 9'h106, 9'h105, 9'h104,
                                         9'h103, 9'h102, 9'h101, 9'h100};
    localparam logic [7:0]  BADV_MASK = 8'b1010_0110;

    typedef struct packed {
        logic [31:0]   pc;
        logic          gr_we;
        logic [4:0]    dest;
        logic [31:0]   result;
        logic          csr_re;
        logic          csr_we;
        logic [CW-1:0] csr_num;
        logic [31:0]   wmask;
        logic [31:0]   wvalue;
        logic          ertn;
        logic [7:0]    ex;
        logic [31:0]   vaddr;
    } instr_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic csr_busy = 1'b0;
    logic [CW-1:0] csr_num;
    logic [31:0] csr_rvalue, csr_wmask, csr_wvalue, wb_pc, wb_badv, rf_wdata;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic csr_we, wb_ex, ertn_flush, wb_badv_we, rf_we;
    logic [5:0] wb_ecode;
    logic [8:0] wb_esubcode;
    logic [4:0] rf_waddr, debug_wb_rf_wnum;
    logic [3:0] debug_wb_rf_we;
    logic [CNT_W-1:0] instret;

    wb_stage_ex_if #(.NUM_EX(NUM_EX), .CSR_NUM_W(CW)) ms_if ();

    wb_stage_ex #(.NUM_EX(NUM_EX), .ECODE_TAB(ECODE_TAB), .ESUB_TAB(ESUB_TAB),
                  .BADV_MASK(BADV_MASK), .CNT_W(CNT_W), .CSR_NUM_W(CW)) dut (
        .clk(clk), .resetn(resetn), .ms(ms_if.slave), .csr_busy(csr_busy),
        .csr_num(csr_num), .csr_rvalue(csr_rvalue), .csr_we(csr_we),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex),
        .ertn_flush(ertn_flush), .wb_pc(wb_pc), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_badv_we(wb_badv_we), .wb_badv(wb_badv),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .instret(instret), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    // CSR file stand-in: read value is a fixed function of the CSR number.
    function automatic logic [31:0] rval(input logic [CW-1:0] n);
        return {n, 18'h0} ^ 32'h1357_9BDF;
    endfunction
    assign csr_rvalue = rval(csr_num);

    int n_chk = 0;
    int n_pass = 0;
    logic [287:0] exp_q[$];
    bit  occ = 0, occ_fl = 0;   // stage holds an instruction / it will flush
    int  mcnt = 0;              // retired count, modulo 2^CNT_W

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%h exp=%h", name, act, exp);
    endtask

    // Commit snapshot; fields irrelevant to the enables present are zeroed.
    function automatic logic [287:0] mk(
        input logic ex, input logic er, input logic rwe, input logic [4:0] wa,
        input logic [31:0] wd, input logic cwe, input logic [CW-1:0] cn,
        input logic [31:0] cm, input logic [31:0] cv, input logic [5:0] ec,
        input logic [8:0] es, input logic bwe, input logic [31:0] bv,
        input logic [31:0] pc, input logic [CNT_W-1:0] ir, input logic [3:0] dwe,
        input logic [4:0] dn, input logic [31:0] dd, input logic [31:0] dpc);
        if (!rwe) begin wa = '0; wd = '0; dn = '0; dd = '0; end
        if (!cwe) begin cn = '0; cm = '0; cv = '0; end
        if (!bwe) bv = '0;
        return 288'({ex, er, rwe, wa, wd, cwe, cn, cm, cv, ec, es, bwe, bv,
                     pc, ir, dwe, dn, dd, dpc});
    endfunction

    // Reference: what committing instruction i must look like.
    task automatic model(input instr_t i, input int cnt, output logic [287:0] v,
                         output bit visible, output bit flushy, output bit exa);
        int k = -1;
        logic [5:0] ec = '0;
        logic [8:0] es = '0;
        logic bwe = 1'b0;
        logic ert, rwe, cwe;
        logic [31:0] wd;
        for (int b = 0; b < NUM_EX; b++) if (i.ex[b] && k < 0) k = b;
        exa = (k >= 0);
        if (exa) begin
            ec  = ECODE_TAB[6*k +: 6];
            es  = ESUB_TAB[9*k +: 9];
            bwe = BADV_MASK[k];
        end
        ert = i.ertn && !exa;
        rwe = i.gr_we && !exa;
        cwe = i.csr_we && !exa;
        wd  = i.csr_re ? rval(i.csr_num) : i.result;
        v = mk(exa, ert, rwe, i.dest, wd, cwe, i.csr_num, i.wmask, i.wvalue,
               ec, es, bwe, i.vaddr, i.pc, CNT_W'(cnt), {4{rwe}}, i.dest, wd, i.pc);
        visible = exa || ert || rwe || cwe;
        flushy  = exa || i.ertn;
    endtask

    // Monitor.
    always @(negedge clk) begin
        if (resetn && (rf_we || csr_we || wb_ex || ertn_flush)) begin
            logic [287:0] act;
            act = mk(wb_ex, ertn_flush, rf_we, rf_waddr, rf_wdata, csr_we, csr_num,
                     csr_wmask, csr_wvalue, wb_ecode, wb_esubcode, wb_badv_we,
                     wb_badv, wb_pc, instret, debug_wb_rf_we, debug_wb_rf_wnum,
                     debug_wb_rf_wdata, debug_wb_pc);
            if (exp_q.size() == 0) chk("unexpected_commit", act, '0);
            else chk("commit", act, exp_q.pop_front());
        end
    end

    // One cycle: apply inputs, decide acceptance before the edge, advance.
    task automatic step(input bit v, input instr_t ins, input bit busy, input int exp_allow);
        logic [287:0] e;
        bit vis, fl, exa;
        ms_if.ms_to_ws_valid = v;
        ms_if.in_pc = ins.pc;           ms_if.in_gr_we = ins.gr_we;
        ms_if.in_dest = ins.dest;       ms_if.in_result = ins.result;
        ms_if.in_csr_re = ins.csr_re;   ms_if.in_csr_we = ins.csr_we;
        ms_if.in_csr_num = ins.csr_num; ms_if.in_csr_wmask = ins.wmask;
        ms_if.in_csr_wvalue = ins.wvalue;
        ms_if.in_ertn = ins.ertn;       ms_if.in_ex_vec = ins.ex;
        ms_if.in_vaddr = ins.vaddr;
        csr_busy = busy;
        @(negedge clk);
        if (exp_allow >= 0) chk("ws_allow_in", 288'(ms_if.ws_allow_in), 288'(exp_allow));
        if (resetn && ms_if.ws_allow_in) begin
            if (v && !(occ && occ_fl)) begin
                model(ins, mcnt, e, vis, fl, exa);
                if (vis) exp_q.push_back(e);
                if (!exa) mcnt = (mcnt + 1) % (1 << CNT_W);
                occ = 1; occ_fl = fl;
            end else begin
                occ = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t alu(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r);
        instr_t i = '0;
        i.pc = pc; i.gr_we = 1'b1; i.dest = d; i.result = r; i.vaddr = ~pc;
        return i;
    endfunction

    function automatic instr_t rnd();
        instr_t i;
        i.pc = $urandom & 32'hFFFF_FFFC;
        i.gr_we = ($urandom_range(0, 9) < 7);
        i.dest = 5'($urandom);
        i.result = $urandom;
        i.csr_re = ($urandom_range(0, 9) < 3);
        i.csr_we = ($urandom_range(0, 9) < 2);
        i.csr_num = CW'($urandom);
        i.wmask = $urandom;
        i.wvalue = $urandom;
        i.ertn = ($urandom_range(0, 9) == 0);
        i.ex = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h0;
        i.vaddr = $urandom;
        return i;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        exp_q.delete();
        occ = 0; occ_fl = 0; mcnt = 0;
    endtask

    initial begin
        instr_t i, z;
        z = '0;
        do_reset();
        step(0, z, 0, -1);
        chk("reset_instret", 288'(instret), '0);
        chk("reset_allow_in", 288'(ms_if.ws_allow_in), 288'(1));
        chk("reset_enables", 288'({rf_we, csr_we, wb_ex, ertn_flush}), '0);
        resetn = 1'b1;
        step(0, z, 0, 1);

        // Plain ALU retire, then counter visible one cycle later.
        step(1, alu(32'h1C00_0000, 5'd5, 32'hDEAD_BEEF), 0, 1);
        step(0, z, 0, 1);
        chk("alu_instret", 288'(instret), 288'(1));

        // Exception from bits 1|2: bit 1 wins; next valid input is dropped.
        i = alu(32'h1C00_0004, 5'd6, 32'h1111_2222);
        i.csr_we = 1'b1; i.ex = 8'b0000_0110; i.vaddr = 32'hBAD0_0000;
        step(1, i, 0, 1);
        step(1, alu(32'h1C00_0008, 5'd7, 32'h3333_4444), 0, 1);
        step(0, z, 0, 1);
        chk("ex_drop_instret", 288'(instret), 288'(1));

        // ertn together with exception bit 0: exception wins.
        i = alu(32'h1C00_0010, 5'd8, 32'h5); i.ertn = 1'b1; i.ex = 8'h01;
        step(1, i, 0, 1);
        step(0, z, 0, 1);
        // ertn alone: flush and count.
        i = '0; i.pc = 32'h1C00_0014; i.ertn = 1'b1;
        step(1, i, 0, 1);
        step(0, z, 0, 1);
        chk("ertn_instret", 288'(instret), 288'(mcnt));

        // csrrd held three cycles by a busy CSR file.
        i = alu(32'h1C00_0020, 5'd9, 32'h0); i.csr_re = 1'b1; i.csr_num = 14'h0005;
        step(1, i, 0, 1);
        for (int c = 0; c < 3; c++) step(1, alu(32'h1C00_0024, 5'd10, 32'h77), 1, 0);
        step(1, alu(32'h1C00_0024, 5'd10, 32'h77), 0, 1);
        step(0, z, 0, -1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            bit v = ($urandom_range(0, 3) != 0);
            step(v, v ? rnd() : z, ($urandom_range(0, 9) < 4), -1);
        end
        for (int n = 0; n < 4; n++) step(0, z, 0, -1);
        chk("drain_queue_empty", 288'(exp_q.size()), '0);
        chk("random_instret", 288'(instret), 288'(mcnt));

        // Reset in the middle of a CSR stall: no write may ever appear.
        i = alu(32'h1C00_0040, 5'd11, 32'h99); i.csr_we = 1'b1; i.csr_num = 14'h0007;
        step(1, i, 0, 1);
        step(0, z, 1, 0);
        do_reset();
        step(0, z, 1, 1);
        chk("stall_reset_instret", 288'(instret), '0);
        chk("stall_reset_writes", 288'({rf_we, csr_we}), '0);
        resetn = 1'b1;
        step(0, z, 1, 1);
        step(0, z, 0, 1);

        // 17 retires on a 4-bit counter wrap to 1.
        for (int n = 0; n < 17; n++) step(1, alu(32'h1C00_1000 + 4*n, 5'(n), 32'(n)), 0, 1);
        step(0, z, 0, 1);
        chk("wrap_instret", 288'(instret), 288'(1));
        chk("final_queue_empty", 288'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
